// File: rtl/bp_be_late_wb_arb.sv
// bp_be_late_wb_arb
//   Merges late integer writeback packets from the memory pipe (D$ late load)
//   and the long-latency pipe onto the single late write port of the integer
//   register file. Each producer is decoupled by a small circular FIFO and the
//   two FIFO heads are served round-robin. Packets are carried opaquely.
//
//   The packet width is a parameter so the block stands alone. Set it to the
//   bp_be_wb_pkt_s width of the target processor configuration.

// Per-source FIFO: registered storage, no flow-through and no full-bypass.
module bp_be_late_wb_fifo
  #(parameter int unsigned pkt_width_p = 77
  , parameter int unsigned els_p       = 2
  )
  (input  logic                   clk_i
  , input  logic                   reset_n_i
  , input  logic [pkt_width_p-1:0] pkt_i
  , input  logic                   v_i
  , output logic                   yumi_o
  , input  logic                   deq_i
  , output logic [pkt_width_p-1:0] head_o
  , output logic                   empty_o
  , output logic                   full_o
  );

  // Pointer width follows the depth; depth is a power of two so pointers wrap naturally.
  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

  logic [pkt_width_p-1:0] mem_r [els_p];
  logic [ptr_w_lp-1:0]    rptr_r;
  logic [ptr_w_lp-1:0]    wptr_r;
  logic [cnt_w_lp-1:0]    count_r;
  logic                   enq_s;
  logic                   deq_s;

  assign full_o  = (count_r == cnt_w_lp'(els_p));
  assign empty_o = (count_r == cnt_w_lp'(0));

  // Accept only when not full; a dequeue in the same cycle does not free a slot early.
  // Gating with reset keeps the handshake quiet while reset is held.
  assign yumi_o = v_i & ~full_o & reset_n_i;
  assign enq_s  = yumi_o;
  assign deq_s  = deq_i & ~empty_o;

  assign head_o = mem_r[rptr_r];

  // Packet storage; contents are meaningless unless covered by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      mem_r[wptr_r] <= pkt_i;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous enqueue and dequeue leave the count unchanged.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq_s) begin
        wptr_r <= wptr_r + ptr_w_lp'(1);
      end
      if (deq_s) begin
        rptr_r <= rptr_r + ptr_w_lp'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// Two-source round-robin late writeback arbiter.
module bp_be_late_wb_arb
  #(parameter int unsigned fifo_els_p     = 2
  , parameter int unsigned wb_pkt_width_p = 77
  , localparam int unsigned wb_pkt_width_lp = wb_pkt_width_p
  )
  (input  logic                       clk_i
  , input  logic                       reset_n_i

  , input  logic [wb_pkt_width_lp-1:0] mem_pkt_i
  , input  logic                       mem_v_i
  , output logic                       mem_yumi_o

  , input  logic [wb_pkt_width_lp-1:0] long_pkt_i
  , input  logic                       long_v_i
  , output logic                       long_yumi_o

  , output logic [wb_pkt_width_lp-1:0] iwb_pkt_o
  , output logic                       iwb_v_o
  , input  logic                       iwb_ready_i

  , output logic                       pending_o
  , output logic                       mem_full_o
  , output logic                       long_full_o
  );

  logic [wb_pkt_width_lp-1:0] mem_head_s;
  logic [wb_pkt_width_lp-1:0] long_head_s;
  logic                       mem_empty_s;
  logic                       long_empty_s;
  logic                       mem_full_s;
  logic                       long_full_s;
  logic                       mem_deq_s;
  logic                       long_deq_s;
  logic                       grant_long_s;
  logic                       xfer_s;
  logic                       last_r;   // 0 = mem served last, 1 = long served last

  bp_be_late_wb_fifo
    #(.pkt_width_p(wb_pkt_width_lp)
    , .els_p      (fifo_els_p)
    )
    mem_fifo
    (.clk_i    (clk_i)
    , .reset_n_i(reset_n_i)
    , .pkt_i    (mem_pkt_i)
    , .v_i      (mem_v_i)
    , .yumi_o   (mem_yumi_o)
    , .deq_i    (mem_deq_s)
    , .head_o   (mem_head_s)
    , .empty_o  (mem_empty_s)
    , .full_o   (mem_full_s)
    );

  bp_be_late_wb_fifo
    #(.pkt_width_p(wb_pkt_width_lp)
    , .els_p      (fifo_els_p)
    )
    long_fifo
    (.clk_i    (clk_i)
    , .reset_n_i(reset_n_i)
    , .pkt_i    (long_pkt_i)
    , .v_i      (long_v_i)
    , .yumi_o   (long_yumi_o)
    , .deq_i    (long_deq_s)
    , .head_o   (long_head_s)
    , .empty_o  (long_empty_s)
    , .full_o   (long_full_s)
    );

  // Grant: a lone nonempty source wins; on a tie the source not served last wins.
  always_comb begin
    grant_long_s = 1'b0;
    if (!mem_empty_s && !long_empty_s) begin
      grant_long_s = ~last_r;
    end else if (!long_empty_s) begin
      grant_long_s = 1'b1;
    end else begin
      grant_long_s = 1'b0;
    end
  end

  // Output mux: the granted head; the grant may move while the port is stalled.
  always_comb begin
    iwb_pkt_o = mem_head_s;
    if (grant_long_s) begin
      iwb_pkt_o = long_head_s;
    end else begin
      iwb_pkt_o = mem_head_s;
    end
  end

  assign iwb_v_o     = ~mem_empty_s | ~long_empty_s;
  assign xfer_s      = iwb_v_o & iwb_ready_i;
  assign mem_deq_s   = xfer_s & ~grant_long_s;
  assign long_deq_s  = xfer_s &  grant_long_s;

  assign pending_o   = ~mem_empty_s | ~long_empty_s;
  assign mem_full_o  = mem_full_s;
  assign long_full_o = long_full_s;

  // Round-robin history: updated only on a completed transfer; reset favours mem on the first tie.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_r <= 1'b1;
    end else if (xfer_s) begin
      last_r <= grant_long_s;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: tb/tb_bp_be_late_wb_arb.sv
// Self-checking bench for bp_be_late_wb_arb. Accepted packets are pushed to
// per-source expectation queues; a monitor pops them as the DUT transfers,
// choosing the source with the round-robin rule.
module tb_bp_be_late_wb_arb;

  localparam int unsigned W  = 77;
  localparam int unsigned FE = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] mem_pkt = '0;
  logic         mem_v = 1'b0;
  logic         mem_yumi;
  logic [W-1:0] long_pkt = '0;
  logic         long_v = 1'b0;
  logic         long_yumi;
  logic [W-1:0] iwb_pkt;
  logic         iwb_v;
  logic         iwb_ready = 1'b0;
  logic         pending;
  logic         mem_full;
  logic         long_full;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  logic [W-1:0] mem_q[$];
  logic [W-1:0] long_q[$];
  logic         model_last = 1'b1;

  bp_be_late_wb_arb #(.fifo_els_p(FE), .wb_pkt_width_p(W)) dut
    (.clk_i(clk), .reset_n_i(reset_n)
    , .mem_pkt_i(mem_pkt), .mem_v_i(mem_v), .mem_yumi_o(mem_yumi)
    , .long_pkt_i(long_pkt), .long_v_i(long_v), .long_yumi_o(long_yumi)
    , .iwb_pkt_o(iwb_pkt), .iwb_v_o(iwb_v), .iwb_ready_i(iwb_ready)
    , .pending_o(pending), .mem_full_o(mem_full), .long_full_o(long_full)
    );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input int src, input int rd);
    logic [W-1:0] p;
    p = '0;
    p[7:0] = 8'(rd);
    p[8] = src[0];
    p[W-1 -: 32] = 32'hA5C3_0000 ^ 32'(rd * 977 + src * 131);
    return p;
  endfunction

  // Scoreboard monitor: expected valid and packet from the model queues.
  initial begin
    logic         exp_v;
    logic         g;
    logic [W-1:0] exp_pkt;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n) begin
        exp_v = (mem_q.size() != 0) || (long_q.size() != 0);
        n_checks++;
        if (iwb_v !== exp_v) begin
          n_fail++;
          $display("FAIL sb_valid: got %b expected %b at %0t", iwb_v, exp_v, $time);
        end else if (exp_v && iwb_ready) begin
          if (mem_q.size() != 0 && long_q.size() != 0) g = ~model_last;
          else g = (long_q.size() != 0);
          exp_pkt = g ? long_q[0] : mem_q[0];
          n_checks++;
          if (iwb_pkt !== exp_pkt) begin
            n_fail++;
            $display("FAIL sb_pkt: got %h expected %h at %0t", iwb_pkt, exp_pkt, $time);
          end
          if (g) void'(long_q.pop_front());
          else void'(mem_q.pop_front());
          model_last = g;
          n_out++;
        end
      end
    end
  end

  task automatic drive(input logic mv, input logic [W-1:0] mp, input logic lv,
                       input logic [W-1:0] lp, input logic rdy);
    @(negedge clk);
    mem_v = mv; mem_pkt = mp; long_v = lv; long_pkt = lp; iwb_ready = rdy;
    #1;
  endtask

  task automatic commit(input logic am, input logic al);
    #2;
    if (am) mem_q.push_back(mem_pkt);
    if (al) long_q.push_back(long_pkt);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; mem_v = 1'b0; long_v = 1'b0; iwb_ready = 1'b0;
    mem_q.delete(); long_q.delete(); model_last = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; mem_v = 1'b1; long_v = 1'b1; iwb_ready = 1'b1;
    mem_pkt = mk(0, 1); long_pkt = mk(1, 1);
    mem_q.delete(); long_q.delete(); model_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({mem_yumi, long_yumi, iwb_v, pending, mem_full, long_full} !== 6'b000000) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b expected 000000", {mem_yumi, long_yumi, iwb_v, pending, mem_full, long_full});
      end
      @(negedge clk);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (mem_yumi !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_yumi: got %b expected 1", mem_yumi);
    end
    mem_v = 1'b0; long_v = 1'b0;
  endtask

  task automatic test_single();
    int start;
    logic em;
    drive(1'b1, mk(0, 5), 1'b0, '0, 1'b1);
    n_checks++;
    if (mem_yumi !== 1'b1) begin n_fail++; $display("FAIL single_yumi: got %b expected 1", mem_yumi); end
    commit(1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    n_checks++;
    if ({iwb_v, pending} !== 2'b11 || iwb_pkt !== mk(0, 5)) begin
      n_fail++;
      $display("FAIL single_out: got v=%b p=%b pkt=%h expected v=1 p=1 pkt=%h", iwb_v, pending, iwb_pkt, mk(0, 5));
    end
    commit(1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    n_checks++;
    if ({iwb_v, pending} !== 2'b00) begin n_fail++; $display("FAIL single_pending_fall: got %b expected 00", {iwb_v, pending}); end
    commit(1'b0, 1'b0);
    start = n_out;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, mk(0, 40 + i), 1'b0, '0, 1'b1);
      em = (mem_q.size() < FE);
      n_checks++;
      if (mem_yumi !== 1'b1 || em !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_yumi[%0d]: got %b expected 1", i, mem_yumi);
      end
      commit(em, 1'b0);
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    commit(1'b0, 1'b0);
    n_checks++;
    if (n_out - start != 10) begin n_fail++; $display("FAIL burst_count: got %0d expected 10", n_out - start); end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    n_checks++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL burst_idle: got %b expected 0", pending); end
  endtask

  task automatic test_tie();
    logic [W-1:0] order [4];
    apply_reset();
    drive(1'b1, mk(0, 1), 1'b1, mk(1, 11), 1'b0);
    n_checks++;
    if ({mem_yumi, long_yumi} !== 2'b11) begin n_fail++; $display("FAIL tie_fill0: got %b expected 11", {mem_yumi, long_yumi}); end
    commit(1'b1, 1'b1);
    drive(1'b1, mk(0, 2), 1'b1, mk(1, 12), 1'b0);
    n_checks++;
    if ({mem_yumi, long_yumi} !== 2'b11) begin n_fail++; $display("FAIL tie_fill1: got %b expected 11", {mem_yumi, long_yumi}); end
    commit(1'b1, 1'b1);
    order[0] = mk(0, 1); order[1] = mk(1, 11); order[2] = mk(0, 2); order[3] = mk(1, 12);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      n_checks++;
      if (iwb_pkt !== order[i]) begin n_fail++; $display("FAIL tie_order[%0d]: got %h expected %h", i, iwb_pkt, order[i]); end
      commit(1'b0, 1'b0);
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    n_checks++;
    if (iwb_v !== 1'b0) begin n_fail++; $display("FAIL tie_empty: got %b expected 0", iwb_v); end
  endtask

  task automatic test_backpressure();
    int am = 0;
    int al = 0;
    int start;
    logic em, el;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, mk(0, 60 + am), 1'b1, mk(1, 70 + al), 1'b0);
      em = (mem_q.size() < FE);
      el = (long_q.size() < FE);
      n_checks++;
      if ({mem_yumi, long_yumi} !== {2{c < 2}}) begin
        n_fail++;
        $display("FAIL bp_yumi[%0d]: got %b expected %b", c, {mem_yumi, long_yumi}, {2{c < 2}});
      end
      if (c >= 2) begin
        n_checks++;
        if ({mem_full, long_full} !== 2'b11) begin n_fail++; $display("FAIL bp_full[%0d]: got %b expected 11", c, {mem_full, long_full}); end
      end
      commit(em, el);
      if (em) am++;
      if (el) al++;
    end
    start = n_out;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      commit(1'b0, 1'b0);
    end
    n_checks++;
    if (n_out - start != 4) begin n_fail++; $display("FAIL bp_drain: got %0d expected 4", n_out - start); end
    drive(1'b1, mk(0, 99), 1'b0, '0, 1'b1);
    n_checks++;
    if (mem_yumi !== 1'b1) begin n_fail++; $display("FAIL bp_resume: got %b expected 1", mem_yumi); end
    commit(1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    commit(1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    commit(1'b0, 1'b0);
  endtask

  task automatic test_full_deq();
    apply_reset();
    drive(1'b1, mk(0, 21), 1'b0, '0, 1'b0);
    commit(1'b1, 1'b0);
    drive(1'b1, mk(0, 22), 1'b0, '0, 1'b0);
    commit(1'b1, 1'b0);
    drive(1'b1, mk(0, 23), 1'b0, '0, 1'b1);
    n_checks++;
    if ({mem_full, mem_yumi} !== 2'b10) begin n_fail++; $display("FAIL fulldeq_block: got %b expected 10", {mem_full, mem_yumi}); end
    commit(1'b0, 1'b0);
    drive(1'b1, mk(0, 23), 1'b0, '0, 1'b1);
    n_checks++;
    if (mem_yumi !== 1'b1) begin n_fail++; $display("FAIL fulldeq_next: got %b expected 1", mem_yumi); end
    commit(1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    commit(1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    n_checks++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL fulldeq_drained: got %b expected 0", pending); end
    commit(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int am = 0;
    int al = 0;
    int start;
    logic em, el;
    apply_reset();
    start = n_out;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, mk(0, 100 + am), 1'b1, mk(1, 150 + al), 1'b1);
      em = (mem_q.size() < FE);
      el = (long_q.size() < FE);
      n_checks++;
      if ({mem_yumi, long_yumi} !== {em, el}) begin
        n_fail++;
        $display("FAIL b2b_yumi[%0d]: got %b expected %b", c, {mem_yumi, long_yumi}, {em, el});
      end
      if (c > 0) begin
        n_checks++;
        if (iwb_v !== 1'b1) begin n_fail++; $display("FAIL b2b_rate[%0d]: got %b expected 1", c, iwb_v); end
      end
      commit(em, el);
      if (em) am++;
      if (el) al++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      commit(1'b0, 1'b0);
    end
    n_checks++;
    if (n_out - start != am + al || am - al > 1 || al > am) begin
      n_fail++;
      $display("FAIL b2b_share: got out=%0d mem=%0d long=%0d expected balanced", n_out - start, am, al);
    end
  endtask

  task automatic test_reset_middrain();
    apply_reset();
    drive(1'b1, mk(0, 201), 1'b1, mk(1, 211), 1'b0);
    commit(1'b1, 1'b1);
    drive(1'b1, mk(0, 202), 1'b0, '0, 1'b0);
    commit(1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    commit(1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    #0.5;
    n_checks++;
    if ({iwb_v, pending, mem_full, long_full} !== 4'b0000) begin
      n_fail++;
      $display("FAIL middrain_reset: got %b expected 0000", {iwb_v, pending, mem_full, long_full});
    end
    mem_q.delete(); long_q.delete(); model_last = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      n_checks++;
      if ({iwb_v, pending} !== 2'b00) begin n_fail++; $display("FAIL middrain_stale[%0d]: got %b expected 00", i, {iwb_v, pending}); end
      commit(1'b0, 1'b0);
    end
  endtask

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_full_deq();
    test_back_to_back();
    test_reset_middrain();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
